// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the iterative multiply/divide unit
//
// Contents:
//   XLEN_DEFAULT      default operand/result width
//   OP_*              operation encodings carried on the op port
//   state_e           FSM states ST_IDLE / ST_CALC / ST_DONE
//   cnt_width()       iteration counter width for a given XLEN
//   CNT_W             counter width at XLEN_DEFAULT
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic int cnt_width(input int xlen);
    return (xlen > 1) ? $clog2(xlen) : 1;
  endfunction

  localparam int CNT_W = cnt_width(XLEN_DEFAULT);

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration of shift-add multiply or restoring divide
//
// Ports:
//   is_div_i  in   1        1 = divide iteration, 0 = multiply iteration
//   acc_i     in   2*XLEN   current accumulator {hi, lo}
//   b_i       in   XLEN     multiplicand (multiply) or divisor (divide)
//   acc_o     out  2*XLEN   accumulator after this iteration
//
// Accumulator layout:
//   multiply: hi = partial product, lo = remaining multiplier bits (consumed LSB first)
//   divide:   hi = partial remainder, lo = dividend bits shifting out / quotient bits shifting in
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_diff;
  logic            div_ok;
  logic [XLEN-1:0] div_rem;
  logic            unused_bits;

  // Multiply: add multiplicand into the high half when the current multiplier
  // bit is set, then shift the whole register right by one (carry enters MSB).
  assign mul_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, b_i} : '0);

  // Divide: remainder gets the next dividend bit; the extra guard bit keeps the
  // shifted value exact, and the top bit of the wider difference is the borrow.
  assign div_shift = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, b_i};
  assign div_ok    = ~div_diff[XLEN+1];
  // The kept remainder is always below the divisor, so its bit XLEN is zero.
  assign div_rem   = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];

  assign unused_bits = ^{div_diff[XLEN], div_shift[XLEN]};

  always_comb begin
    acc_o = '0;
    if (is_div_i) begin
      acc_o = {div_rem, acc_i[XLEN-2:0], div_ok};
    end else begin
      acc_o = {mul_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative unsigned MUL/MULHU/DIVU/REMU unit feeding the register file write port
//
// Ports:
//   CLK      in   1     clock, rising edge
//   rst      in   1     asynchronous active-low reset
//   start    in   1     request pulse, accepted only when idle and not busy
//   op       in   2     00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   rs1_val  in   XLEN  operand A (multiplicand / dividend)
//   rs2_val  in   XLEN  operand B (multiplier / divisor)
//   rd_in    in   5     destination register index
//   busy     out  1     high from the cycle after acceptance until done clears
//   done     out  1     one-cycle pulse, result valid
//   result   out  XLEN  registered result, held until the next completion
//   rd_out   out  5     latched destination index (register file A3)
//   we_out   out  1     done gated by rd_out != 0 (register file WE3)
//
// Build option:
//   MULDIV_EARLY_OUT_EN  divide-by-zero and zero-operand multiplies skip CALC
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out
);

  localparam int CW = (XLEN == XLEN_DEFAULT) ? CNT_W : cnt_width(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [1:0]        op_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN-1:0]   b_q;
  logic [4:0]        rd_q;
  logic              busy_q;
  logic              done_q;
  logic              we_q;
  logic [XLEN-1:0]   result_q;

  logic              in_is_div;
  logic              q_is_div;
  logic              q_hi_sel;
  logic              early_zero;

  assign in_is_div = (op == OP_DIVU) || (op == OP_REMU);
  assign q_is_div  = (op_q == OP_DIVU) || (op_q == OP_REMU);
  // MULHU and REMU both read the high half of the accumulator.
  assign q_hi_sel  = (op_q == OP_MULHU) || (op_q == OP_REMU);

`ifdef MULDIV_EARLY_OUT_EN
  assign early_zero = (rs2_val == '0) ||
                      (((op == OP_MUL) || (op == OP_MULHU)) && (rs1_val == '0));
`else
  assign early_zero = 1'b0;
`endif

  muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .is_div_i(q_is_div),
    .acc_i   (acc_q),
    .b_i     (b_q),
    .acc_o   (acc_d)
  );

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      acc_q    <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      // busy falls together with the done pulse.
      if (done_q) begin
        busy_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          // The done cycle is spent in IDLE with busy still high; holding off
          // on busy keeps start-while-busy from being accepted there.
          if (start && !busy_q) begin
            op_q   <= op;
            rd_q   <= rd_in;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            b_q    <= in_is_div ? rs2_val : rs1_val;
            if (early_zero) begin
              // Preload the final accumulator: {remainder, quotient} for a
              // zero divisor, all zeros for a zero product.
              acc_q   <= in_is_div ? {rs1_val, {XLEN{1'b1}}} : '0;
              state_q <= ST_DONE;
            end else begin
              acc_q   <= in_is_div ? {{XLEN{1'b0}}, rs1_val} : {{XLEN{1'b0}}, rs2_val};
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q   <= 1'b1;
          we_q     <= (rd_q != 5'd0);
          result_q <= q_hi_sel ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_q;
  assign we_out = we_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            CLK = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [XLEN-1:0] rs1_val = '0;
  logic [XLEN-1:0] rs2_val = '0;
  logic [4:0]      rd_in = '0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            we_out;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(
    .XLEN(XLEN)
  ) dut (
    .CLK    (CLK),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs1_val(rs1_val),
    .rs2_val(rs2_val),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out),
    .we_out (we_out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (b == 0 || (o < 2 && a == 0)) return 2;
`endif
    return 34;
  endfunction

  // Called at a falling edge; returns at a falling edge one cycle after done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit inject);
    logic [31:0] exp;
    int          lat;
    int          cyc;
    exp = model(o, a, b);
    lat = model_lat(o, a, b);
    op = o;
    rs1_val = a;
    rs2_val = b;
    rd_in = rd;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    cyc = 1;
    check("busy_after_start", busy, 1);
    // Scramble inputs to show the operands were latched.
    rs1_val = $urandom;
    rs2_val = $urandom;
    rd_in = 5'($urandom);
    op = 2'($urandom);
    while (done !== 1'b1 && cyc < 100) begin
      start = inject && (cyc == 10);
      @(negedge CLK);
      cyc++;
    end
    start = 1'b0;
    check("latency", cyc, lat);
    check("done", done, 1);
    check("result", result, exp);
    check("rd_out", rd_out, rd);
    check("we_out", we_out, (rd != 0));
    check("busy_in_done", busy, 1);
    @(negedge CLK);
    check("done_pulse", done, 0);
    check("we_pulse", we_out, 0);
    check("busy_clear", busy, 0);
    check("result_hold", result, exp);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;

    rst = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", we_out, 0);
    check("rst_result", result, 0);
    check("rst_rd", rd_out, 0);
    rst = 1'b1;
    @(negedge CLK);

    run_op(2'b00, 32'd6, 32'd10, 5'd7, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    run_op(2'b10, 32'd100, 32'd7, 5'd9, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 5'd9, 1'b0);
    run_op(2'b10, 32'd5, 32'd0, 5'd4, 1'b0);
    run_op(2'b11, 32'd5, 32'd0, 5'd4, 1'b0);
    run_op(2'b00, 32'd0, 32'd1234, 5'd6, 1'b0);
    run_op(2'b10, 32'd1000, 32'd3, 5'd12, 1'b1);
    run_op(2'b00, 32'd7, 32'd9, 5'd0, 1'b0);

    // Asynchronous reset in the middle of CALC.
    op = 2'b10;
    rs1_val = 32'hDEAD_BEEF;
    rs2_val = 32'd17;
    rd_in = 5'd21;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (5) @(negedge CLK);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_result", result, 0);
    check("arst_we", we_out, 0);
    check("arst_rd", rd_out, 0);
    @(negedge CLK);
    rst = 1'b1;
    repeat (40) @(negedge CLK);
    check("arst_discarded_done", done, 0);
    check("arst_discarded_busy", busy, 0);
    run_op(2'b00, 32'd3, 32'd4, 5'd5, 1'b0);

    for (int i = 0; i < 20; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 255);
        default: b = $urandom;
      endcase
      run_op(2'($urandom), a, b, 5'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
